bg_scroll_sched: RTL
====================

Name: bg_scroll_sched

Overview:
- Sequences the horizontal scroll and mirror state of the scaled background bitgen: produces `scroll_offset` and `flip_phase`.
- Step ticks accumulate during the frame; position updates are committed only at the start of vertical blanking, so the image never tears mid-frame.
- A valid/ready command port lets the game CPU/MMIO layer change speed, pause/resume, or reset the position. Commands also take effect at a frame boundary.
- Sits between the MMIO/CPU bus and the background bitgen; `hcount`/`vcount` come from the VGA timing block.

Parameters:
- BG_WIDTH, 180: background image width in pixels; scroll wrap modulus.
- DEFAULT_PERIOD, 26'd1600000: `pix_clk` cycles per scroll step after reset.
- V_ACTIVE, 480: first blanking line; defines the frame boundary.

Ports:
- pix_clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- hcount  in  10  horizontal counter from VGA timing
- vcount  in  10  vertical counter from VGA timing
- dir  in  1  0 = offset increments, 1 = offset decrements; sampled at the boundary
- cmd_valid  in  1  command request
- cmd_ready  out  1  command slot free
- cmd_op  in  2  00 SET_PERIOD, 01 PAUSE, 10 RESUME, 11 RESET_POS
- cmd_data  in  26  new period (SET_PERIOD only)
- scroll_offset  out  16  committed scroll offset, range 0..BG_WIDTH-1
- flip_phase  out  1  committed mirror phase
- frame_tick  out  1  one-cycle pulse on each frame boundary
- running  out  1  1 = RUN state

Behaviour:
- Reset values (async): `scroll_offset`=0, `flip_phase`=0, `frame_tick`=0, `running`=1, `cmd_ready`=1. Internally: period=DEFAULT_PERIOD, tick counter=0, pending=0, shadow command empty.
- Frame boundary (`fb`):
  - `cond = (vcount==V_ACTIVE && hcount==0)`.
  - `fb` = `cond & ~cond_q`, i.e. rising edge only. If `cond` is held for several cycles, there is exactly one `fb`.
  - `frame_tick` is registered: high the cycle after `fb`.
- State machine:
  - RUN:
    - Tick counter increments each cycle.
    - When counter == period-1: counter←0, pending←pending+1, saturating at BG_WIDTH-1.
  - PAUSED:
    - Tick counter and pending hold.
  - Reset enters RUN.
- Commands:
  - A command is accepted on `cmd_valid && cmd_ready`.
  - On accept, `cmd_op`/`cmd_data` are latched into the shadow register and `cmd_ready` drops the next cycle.
  - `cmd_ready` stays low until the shadow is applied at the next `fb`, and rises the cycle after that `fb`.
  - Only one command is in flight.
  - If accept and `fb` occur in the same cycle, the command waits for the following `fb`.
- Commit at `fb`, in this order:
  1. Apply pending steps, p = pending.
     - dir=0: s = offset + p. If s ≥ BG_WIDTH: offset←s−BG_WIDTH, flip toggles.
     - dir=1: if p > offset: offset←offset+BG_WIDTH−p, flip toggles; otherwise offset←offset−p.
     - Use ≥17-bit intermediates.
  2. pending←0. If a tick occurs in this same cycle, pending←1, i.e. the tick belongs to the next frame.
  3. Apply the shadow command, if any:
     - SET_PERIOD: period←`cmd_data`, counter←0. A `cmd_data` of 0 is accepted but ignored (period unchanged).
     - PAUSE: →PAUSED, `running`←0.
     - RESUME: →RUN, `running`←1. No-op if already in RUN.
     - RESET_POS: overrides step 1; offset←0, flip←0, counter←0.
- `scroll_offset`/`flip_phase` change only in the cycle after `fb` (registered), never mid-frame.
- Period 1: one tick per cycle; pending saturates at BG_WIDTH-1 within the frame.
- Async reset asserted mid-frame or with a command in flight: everything returns to reset values; the shadow is discarded and `cmd_ready`=1 at the first clock after release.

Test Plan:
Bench uses BG_WIDTH=8, DEFAULT_PERIOD=4, V_ACTIVE=4 and a short timing model (8 columns × 6 lines, one count per clock).

1. Reset then free-run. Frame = 48 cycles → 12 ticks, saturating at 7.
   - First `fb`: `scroll_offset` 0→7, `flip_phase` 0.
   - Second `fb`: 7+7=14 → `scroll_offset`=6, `flip_phase`=1.
   - `frame_tick` is high for exactly 1 cycle per frame.
2. SET_PERIOD `cmd_data`=24 accepted mid-frame.
   - `cmd_ready` goes 0 until the cycle after `fb`.
   - Next frame produces 2 steps.
   - A second `cmd_valid` while `cmd_ready`=0 is not accepted.
3. PAUSE then RESUME.
   - After PAUSE commits: `running`=0, and the offset stays constant across 3 frames.
   - After RESUME commits: the offset advances again from the retained counter/pending values.
4. dir=1 from offset 2 with 5 pending steps → offset 5, `flip_phase` toggles.
5. RESET_POS issued while 7 steps are pending → offset 0, flip 0 after `fb`; no step is applied.
6. Set `rst` mid-frame with a command in flight → outputs return to reset values immediately (async); `cmd_ready`=1 after release.

Source files
------------

// File: rtl/bg_scroll_sched.sv
// bg_scroll_sched: frame-synchronous scroll offset / mirror phase sequencer for the background bitgen
module bg_scroll_sched #(
  parameter int          BG_WIDTH       = 180,
  parameter logic [25:0] DEFAULT_PERIOD = 26'd1600000,
  parameter int          V_ACTIVE       = 480
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        dir,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [25:0] cmd_data,
  output logic [15:0] scroll_offset,
  output logic        flip_phase,
  output logic        frame_tick,
  output logic        running
);
  typedef enum logic {RUN, PAUSED} state_t;
  localparam logic [1:0]  OP_SET_PERIOD = 2'b00;
  localparam logic [1:0]  OP_PAUSE      = 2'b01;
  localparam logic [1:0]  OP_RESUME     = 2'b10;
  localparam logic [1:0]  OP_RESET_POS  = 2'b11;
  localparam logic [16:0] W             = 17'(BG_WIDTH);
  localparam logic [15:0] P_MAX         = 16'(BG_WIDTH - 1);
  state_t      state, state_nx;
  logic        cond, cond_q, fb, tick, accept, apply, wrap_up, wrap_dn, flip_nx;
  logic [25:0] period, period_nx, count, count_nx, sh_data;
  logic [15:0] pending, pending_nx, offset_nx;
  logic [16:0] sum;
  logic        sh_valid;
  logic [1:0]  sh_op;
  assign cond      = vcount == 10'(V_ACTIVE) && hcount == '0;
  assign fb        = cond & ~cond_q;
  assign tick      = state == RUN && count == period - 26'd1;
  assign cmd_ready = ~sh_valid;
  assign running   = state == RUN;
  assign accept    = cmd_valid & cmd_ready;
  assign apply     = fb & sh_valid;
  assign sum       = {1'b0, scroll_offset} + {1'b0, pending};
  assign wrap_up   = sum >= W;
  assign wrap_dn   = pending > scroll_offset;
  always_comb begin
    state_nx   = state;
    period_nx  = period;
    count_nx   = tick ? '0 : (state == RUN ? count + 26'd1 : count);
    pending_nx = tick ? (pending == P_MAX ? pending : pending + 16'd1) : pending;
    offset_nx  = scroll_offset;
    flip_nx    = flip_phase;
    if (fb) begin
      // a tick landing on the boundary cycle is credited to the next frame
      pending_nx = {15'd0, tick};
      offset_nx  = dir ? (wrap_dn ? 16'({1'b0, scroll_offset} + W - {1'b0, pending}) : scroll_offset - pending)
                       : (wrap_up ? 16'(sum - W) : sum[15:0]);
      flip_nx    = flip_phase ^ (dir ? wrap_dn : wrap_up);
    end
    if (apply) begin
      if (sh_op == OP_SET_PERIOD && sh_data != '0) begin
        period_nx = sh_data;
        count_nx  = '0;
      end
      state_nx = sh_op == OP_PAUSE ? PAUSED : (sh_op == OP_RESUME ? RUN : state);
      if (sh_op == OP_RESET_POS) begin
        offset_nx = '0;
        flip_nx   = 1'b0;
        count_nx  = '0;
      end
    end
  end
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cond_q        <= 1'b0;
      frame_tick    <= 1'b0;
      period        <= DEFAULT_PERIOD;
      count         <= '0;
      pending       <= '0;
      scroll_offset <= '0;
      flip_phase    <= 1'b0;
      sh_valid      <= 1'b0;
      sh_op         <= '0;
      sh_data       <= '0;
    end else begin
      state         <= state_nx;
      cond_q        <= cond;
      frame_tick    <= fb;
      period        <= period_nx;
      count         <= count_nx;
      pending       <= pending_nx;
      scroll_offset <= offset_nx;
      flip_phase    <= flip_nx;
      sh_valid      <= accept | (sh_valid & ~fb);
      if (accept) begin
        sh_op   <= cmd_op;
        sh_data <= cmd_data;
      end
    end
  end
endmodule
